// File: rtl/frame_buffer_loader.sv
// Pixel stream loader: writes RGB444 frames into two half-panel RAM banks,
// double-buffered on address bit 11, swapping pages at driver frame boundaries.
// Ports: i_clk, i_rst (async, active-high); i_pix_data/valid/sof in,
// o_pix_ready out; o_wr_addr/data, o_wr_en_b1 (top), o_wr_en_b2 (bottom);
// i_frame_done from driver; o_display_page, o_frame_pending, o_sync_err.
// Optional: define TEST_PATTERN_EN to add i_pattern_start and a generator.
module frame_buffer_loader #(
  parameter int WIDTH     = 64,
  parameter int HALF_ROWS = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [11:0] i_pix_data,
  input  logic        i_pix_valid,
  input  logic        i_pix_sof,
`ifdef TEST_PATTERN_EN
  input  logic        i_pattern_start,
`endif
  output logic        o_pix_ready,
  output logic [11:0] o_wr_addr,
  output logic [11:0] o_wr_data,
  output logic        o_wr_en_b1,
  output logic        o_wr_en_b2,
  input  logic        i_frame_done,
  output logic        o_display_page,
  output logic        o_frame_pending,
  output logic        o_sync_err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = $clog2(2 * HALF_ROWS);
  localparam logic [CW-1:0] COL_MAX  = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_HALF = RW'(HALF_ROWS - 1);
  localparam logic [RW-1:0] ROW_MAX  = RW'(2 * HALF_ROWS - 1);

`ifdef TEST_PATTERN_EN
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_PAT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_t;
`endif

  state_t state;

  // Position of the next pixel; off/bot track the bank offset and bank
  // directly so no multiply or modulo is needed.
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [10:0]   off;
  logic          bot;

  logic          accept, pos_clr, pat_go, do_wr, p_last;
  logic [CW-1:0] p_col, n_col;
  logic [RW-1:0] p_row, n_row;
  logic [10:0]   p_off, n_off;
  logic          p_bot, n_bot;
  logic [11:0]   wdata;

  always_comb begin
    accept  = i_pix_valid && o_pix_ready;
    // A start-of-frame pixel always lands at 0,0, even mid-frame.
    pos_clr = accept && i_pix_sof;
    p_col   = pos_clr ? '0 : col;
    p_row   = pos_clr ? '0 : row;
    p_off   = pos_clr ? '0 : off;
    p_bot   = pos_clr ? 1'b0 : bot;
    p_last  = (p_col == COL_MAX) && (p_row == ROW_MAX);

    n_col = (p_col == COL_MAX) ? '0 : p_col + CW'(1);
    n_row = p_row;
    n_off = p_off + 11'd1;
    n_bot = p_bot;
    if (p_col == COL_MAX) begin
      n_row = (p_row == ROW_MAX) ? '0 : p_row + RW'(1);
      if (p_row == ROW_HALF) begin
        n_off = '0;
        n_bot = 1'b1;
      end
      if (p_row == ROW_MAX) begin
        n_off = '0;
        n_bot = 1'b0;
      end
    end

`ifdef TEST_PATTERN_EN
    pat_go = (state == S_IDLE) && i_pattern_start;
`else
    pat_go = 1'b0;
`endif

    do_wr = 1'b0;
    unique case (state)
      S_IDLE: do_wr = pos_clr && !pat_go;
      S_LOAD: do_wr = accept;
`ifdef TEST_PATTERN_EN
      S_PAT:  do_wr = 1'b1;
`endif
      default: do_wr = 1'b0;
    endcase

    wdata = i_pix_data;
`ifdef TEST_PATTERN_EN
    if (state == S_PAT) begin
      logic [5:0] c6, r6;
      c6 = 6'(p_col);
      r6 = 6'(p_row);
      wdata = {c6[3:0], r6[3:0], c6[5:2] ^ r6[5:2]};
    end
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= S_IDLE;
      o_pix_ready     <= 1'b0;
      o_display_page  <= 1'b0;
      o_frame_pending <= 1'b0;
      o_sync_err      <= 1'b0;
      o_wr_en_b1      <= 1'b0;
      o_wr_en_b2      <= 1'b0;
      o_wr_addr       <= '0;
      o_wr_data       <= '0;
      col             <= '0;
      row             <= '0;
      off             <= '0;
      bot             <= 1'b0;
    end else begin
      o_wr_en_b1 <= 1'b0;
      o_wr_en_b2 <= 1'b0;

      unique case (state)
        S_IDLE: begin
          o_pix_ready <= 1'b1;
          if (pat_go) begin
            state       <= state_t'(3);
            o_pix_ready <= 1'b0;
          end else if (accept && !i_pix_sof) begin
            o_sync_err <= 1'b1;
          end
        end
        S_LOAD: begin
          if (pos_clr) o_sync_err <= 1'b1;
        end
        S_WAIT: begin
          if (i_frame_done) begin
            state           <= S_IDLE;
            o_display_page  <= ~o_display_page;
            o_frame_pending <= 1'b0;
            o_pix_ready     <= 1'b1;
          end
        end
        default: ;
      endcase

      if (do_wr) begin
        o_wr_en_b1 <= ~p_bot;
        o_wr_en_b2 <= p_bot;
        o_wr_addr  <= {~o_display_page, p_off};
        o_wr_data  <= wdata;
        col        <= n_col;
        row        <= n_row;
        off        <= n_off;
        bot        <= n_bot;
        if (p_last) begin
          state           <= S_WAIT;
          o_frame_pending <= 1'b1;
          o_pix_ready     <= 1'b0;
        end else if (state == S_IDLE) begin
          state <= S_LOAD;
        end
      end
    end
  end

endmodule

// File: doc/frame_buffer_loader.md
Name: frame_buffer_loader

Overview:
- Upstream stage of led_matrix_control: takes a raster pixel stream (12-bit RGB444, 4 bits per channel: R[11:8], G[7:4], B[3:0]) and writes it into the two half-panel RAM banks the panel driver scans.
- Bank 1 holds the top half of the panel and bank 2 the bottom half.
- Double-buffered: RAM address bit 11 selects a page. The loader fills the back page while the driver displays the front page.
- Pages swap only at a driver frame boundary, so no frame is ever shown torn.

Parameters:
- WIDTH, 64, pixels per panel row. Power of two.
- HALF_ROWS, 32, rows per bank. WIDTH*HALF_ROWS must be ≤ 2048.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset
- i_pix_data  in  12  RGB444 pixel
- i_pix_valid  in  1  pixel present
- i_pix_sof  in  1  qualifies the first pixel of a frame
- o_pix_ready  out  1  loader can accept a pixel
- o_wr_addr  out  12  {page, offset[10:0]}
- o_wr_data  out  12  pixel to write
- o_wr_en_b1  out  1  write strobe, top bank
- o_wr_en_b2  out  1  write strobe, bottom bank
- i_frame_done  in  1  one-cycle pulse from the panel driver when its row select wraps to 0
- o_display_page  out  1  page the driver must read; the driver uses it as its address bit 11
- o_frame_pending  out  1  full frame loaded, waiting for swap
- o_sync_err  out  1  sticky framing error

Interface decisions:
- One clock; reset is asynchronous and active-high (i_clk, i_rst).

Behaviour:
- Reset values:
  - Control: state=IDLE, o_display_page=0, o_pix_ready=0.
  - Write port: o_wr_en_b1/b2=0, o_wr_addr=0, o_wr_data=0.
  - Status: o_frame_pending=0, o_sync_err=0.
  - Counters: col=0, row=0.
- Reset mid-frame:
  - Discards the partial frame.
  - The displayed page returns to 0.
- Handshake:
  - A pixel is accepted when i_pix_valid && o_pix_ready.
  - o_pix_ready is registered. It is 1 in IDLE and LOAD, and 0 in WAIT_SWAP.
- Write latency:
  - An accepted pixel appears on o_wr_* exactly one cycle later.
  - The write enable lasts one cycle. At most one enable is active per cycle.
- Addressing:
  - Pixel counters col (0..WIDTH-1) and row (0..2*HALF_ROWS-1).
  - row < HALF_ROWS targets b1; otherwise b2.
  - offset = (row mod HALF_ROWS)*WIDTH + col, zero-extended to 11 bits.
  - Page bit = ~o_display_page, i.e. the back page.
  - Counters use increment and wrap only; no divider.
- States:
  - IDLE: waits for an accepted pixel with i_pix_sof=1.
    - That pixel is written at col=0, row=0, and the state goes to LOAD.
    - Accepted pixels with sof=0 are dropped (no write) and set o_sync_err.
  - LOAD: each accepted pixel is written and the counters advance.
    - An accepted pixel with sof=1 restarts the frame: it is written at 0,0 and o_sync_err is set.
    - The last pixel (col=WIDTH-1, row=2*HALF_ROWS-1) is written, then the state goes to WAIT_SWAP.
    - On that transition o_frame_pending=1 and o_pix_ready=0.
  - WAIT_SWAP: holds until i_frame_done.
    - On i_frame_done, o_display_page toggles, o_frame_pending clears, and the state goes to IDLE.
    - o_pix_ready=1 on the next cycle.
- Frame-done timing:
  - i_frame_done in IDLE or LOAD is ignored; the page does not change.
  - i_frame_done in the same cycle the last pixel is accepted is also ignored; only WAIT_SWAP consumes it.
- o_sync_err clears only on reset.

Optional Feature:
- Macro: TEST_PATTERN_EN
- With the macro defined, input i_pattern_start (1 bit) is added.
  - A pulse on it in IDLE enters state PATTERN.
  - PATTERN generates a full frame internally at one pixel per cycle, with pixel = {col[3:0], row[3:0], col[5:2]^row[5:2]}. Addressing and write latency are the same as in LOAD.
  - The stream is not accepted during PATTERN: o_pix_ready=0.
  - PATTERN then goes to WAIT_SWAP as normal.
  - i_pattern_start outside IDLE is ignored.
- Without the macro, the port and the state do not exist.

Test Plan:
- Reset, then stream 4096 pixels (data = index[11:0], sof on the first) -> first write: b1, addr 0x800, data 0x000.
  - Pixel 2047 is written to b1 at 0xFFF.
  - Pixel 2048 is written to b2 at 0x800.
  - Pixel 4095 is written to b2 at 0xFFF.
  - o_frame_pending=1 and o_pix_ready=0 after the last write.
- In WAIT_SWAP, pulse i_frame_done -> o_display_page 0→1, o_pix_ready=1.
  - The next frame writes page 0: first addr 0x000.
- In IDLE, 3 pixels with sof=0, then sof=1 data 0xABC -> no writes for the first 3, o_sync_err=1.
  - 0xABC is written to b1 at 0x800.
- In LOAD after 100 pixels, a pixel with sof=1 -> it is written at 0x800, o_sync_err=1, and the frame completes 4095 pixels later.
- Pulse i_frame_done in IDLE and LOAD, and in the cycle the last pixel is accepted -> o_display_page unchanged.
  - A later pulse in WAIT_SWAP toggles it.
- Assert i_rst mid-LOAD (pixel 1000) -> all outputs return to reset values the same cycle.
  - The next sof frame writes from 0x800 on page 1.
